// File: rtl/arbitro_sched.sv
// Strict-priority scheduler that drains the input VC FIFO bank one word per cycle and
// routes each word, through a one-deep stage register, to the output FIFO named by its
// class field.
module arbitro_sched #(
    parameter int unsigned FifoUnits = 4,
    parameter int unsigned WordSize  = 10,
    parameter int unsigned ClassBits = 2,
    parameter int unsigned CountW    = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [FifoUnits-1:0] in_empty_i,
    input  logic [FifoUnits-1:0] out_almost_full_i,
    input  logic [WordSize-1:0]  fifo_data_in_i,
    output logic [FifoUnits-1:0] pop_o,
    output logic [FifoUnits-1:0] push_o,
    output logic [WordSize-1:0]  data_out_o,
    output logic                 valid_out_o,
    output logic [1:0]           state_out_o,
    output logic [CountW-1:0]    push_count_o
);

    localparam logic [1:0] StIdle   = 2'b00;
    localparam logic [1:0] StActive = 2'b01;
    localparam logic [1:0] StPause  = 2'b10;

    logic [1:0]           state_q, state_d;
    logic [WordSize-1:0]  data_q, data_d;
    logic                 valid_q, valid_d;
    logic [CountW-1:0]    count_q, count_d;
    logic [FifoUnits-1:0] grant_oh;
    logic                 stall;
    logic                 any_ne;
    logic [ClassBits-1:0] word_class;
    logic                 null_word;

    assign stall  = |out_almost_full_i;
    assign any_ne = ~&in_empty_i;

    // Lowest-index non-empty FIFO wins; re-evaluated every cycle, so no packet locking.
    always_comb begin
        logic found;
        grant_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < int'(FifoUnits); i++) begin
            if (!in_empty_i[i] && !found) begin
                grant_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Pop gate uses the live stall so the pop drops in the same cycle almost_full rises.
    always_comb begin
        pop_o = '0;
        if (state_q == StActive && !stall) begin
            pop_o = grant_oh;
        end
    end

    // Next-state logic; stall has priority over new work in every state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = stall ? StPause : (any_ne ? StActive : StIdle);
            StActive: state_d = stall ? StPause : (any_ne ? StActive : StIdle);
            StPause:  state_d = stall ? StPause : (any_ne ? StActive : StIdle);
            default:  state_d = StIdle;
        endcase
    end

    // Stage register capture: load on pop, otherwise hold data and clear valid.
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        if (|pop_o) begin
            data_d  = fifo_data_in_i;
            valid_d = 1'b1;
        end
    end

    // Push decode; an all-zero word (class 0, payload 0) is a null word and is dropped.
    always_comb begin
        word_class = data_q[WordSize-1 -: ClassBits];
        null_word  = (data_q == '0);
        push_o     = '0;
        if (valid_q && !null_word) begin
            push_o = FifoUnits'(1) << word_class;
        end
    end

    // Push counter wraps naturally at its width.
    always_comb begin
        count_d = count_q + CountW'(|push_o);
    end

    // State, stage and counter registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign data_out_o   = data_q;
    assign valid_out_o  = valid_q;
    assign state_out_o  = state_q;
    assign push_count_o = count_q;

endmodule

// File: tb/tb_arbitro_sched.sv
// Self-checking bench for arbitro_sched: behavioural input FIFOs, a reference FSM/pop
// model and a scoreboard of words expected at the stage output.
module tb_arbitro_sched;

    localparam logic [1:0] MIdle   = 2'b00;
    localparam logic [1:0] MActive = 2'b01;
    localparam logic [1:0] MPause  = 2'b10;

    typedef struct packed {
        logic [9:0] w;
        logic [3:0] p;
    } ent_t;

    typedef struct {
        logic [9:0] w;
        logic [3:0] p;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_empty;
    logic [3:0] af;
    logic [9:0] din;
    logic [3:0] pop;
    logic [3:0] push;
    logic [9:0] dout;
    logic       vout;
    logic [1:0] st;
    logic [7:0] cnt;

    ent_t       fq[4][$];
    ent_t       sb[$];
    int         pop_log[$];
    logic [1:0] m_state, m_state_n;
    logic [7:0] m_cnt, m_cnt_n;
    int         pop_idx_n;
    int         checks;
    int         failures;

    arbitro_sched dut (
        .clk_i            (clk),
        .reset_ni         (rst_n),
        .in_empty_i       (in_empty),
        .out_almost_full_i(af),
        .fifo_data_in_i   (din),
        .pop_o            (pop),
        .push_o           (push),
        .data_out_o       (dout),
        .valid_out_o      (vout),
        .state_out_o      (st),
        .push_count_o     (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] route(input logic [9:0] w);
        logic [3:0] r;
        r = 4'b0000;
        if (w != 10'h000) r[w[9:8]] = 1'b1;
        return r;
    endfunction

    function automatic bit busy();
        bit b;
        b = (sb.size() != 0);
        for (int i = 0; i < 4; i++) if (fq[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic load(input int f, input logic [9:0] w, input logic [3:0] p);
        ent_t e;
        e.w = w;
        e.p = p;
        fq[f].push_back(e);
    endtask

    // Step to just after an active edge, where stimulus changes are made.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (busy() && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (n >= bound) begin
            checks++;
            failures++;
            $display("FAIL %s: drain timeout, got busy expected idle", name);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT against the model mid-cycle and compute the model's next state.
    always @(negedge clk) begin
        logic       stall;
        logic       ane;
        int         g;
        logic [3:0] ep;
        ent_t       e;
        stall = |af;
        ane   = 1'b0;
        g     = -1;
        for (int i = 0; i < 4; i++) begin
            if (fq[i].size() != 0) begin
                ane = 1'b1;
                if (g < 0) g = i;
            end
        end
        if (!rst_n) begin
            chk("rst_pop", 32'(pop), 32'h0);
            chk("rst_push", 32'(push), 32'h0);
            chk("rst_valid", 32'(vout), 32'h0);
            chk("rst_count", 32'(cnt), 32'h0);
            chk("rst_state", 32'(st), 32'(MIdle));
            sb.delete();
            m_state_n = MIdle;
            m_cnt_n   = 8'h00;
            pop_idx_n = -1;
        end else begin
            ep = 4'b0000;
            if (m_state == MActive && !stall && g >= 0) ep[g] = 1'b1;
            chk("pop", 32'(pop), 32'(ep));
            chk("state", 32'(st), 32'(m_state));
            chk("count", 32'(cnt), 32'(m_cnt));
            m_cnt_n = m_cnt;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("valid", 32'(vout), 32'h1);
                chk("data", 32'(dout), 32'(e.w));
                chk("push", 32'(push), 32'(e.p));
                if (e.p != 4'b0000) m_cnt_n = m_cnt + 8'd1;
            end else begin
                chk("valid_idle", 32'(vout), 32'h0);
                chk("push_idle", 32'(push), 32'h0);
            end
            pop_idx_n = -1;
            if (ep != 4'b0000) begin
                sb.push_back(fq[g][0]);
                pop_log.push_back(g);
                pop_idx_n = g;
            end
            unique case (m_state)
                MIdle:   m_state_n = stall ? MPause : (ane ? MActive : MIdle);
                MActive: m_state_n = stall ? MPause : (ane ? MActive : MIdle);
                default: m_state_n = stall ? MPause : (ane ? MActive : MIdle);
            endcase
        end
    end

    // Commit the model and the FIFO pops after the edge, then refresh the FIFO outputs.
    always @(posedge clk) begin
        int g;
        #1;
        if (pop_idx_n >= 0) void'(fq[pop_idx_n].pop_front());
        pop_idx_n = -1;
        m_state   = m_state_n;
        m_cnt     = m_cnt_n;
        #2;
        g = -1;
        for (int i = 0; i < 4; i++) begin
            in_empty[i] = (fq[i].size() == 0);
            if (fq[i].size() != 0 && g < 0) g = i;
        end
        din = (g >= 0) ? fq[g][0].w : 10'h000;
    end

    initial begin
        vec_t       tbl[5];
        logic [7:0] base;
        int         n;
        int         ones;
        tbl[0] = '{10'h155, 4'b0010};
        tbl[1] = '{10'h2AA, 4'b0100};
        tbl[2] = '{10'h3FF, 4'b1000};
        tbl[3] = '{10'h001, 4'b0001};
        tbl[4] = '{10'h000, 4'b0000};

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        af        = 4'b0000;
        in_empty  = 4'b1111;
        din       = 10'h000;
        m_state   = MIdle;
        m_state_n = MIdle;
        m_cnt     = 8'h00;
        m_cnt_n   = 8'h00;
        pop_idx_n = -1;

        // Reset held with non-empty FIFOs; this data also feeds the priority test.
        for (int i = 0; i < 3; i++) load(0, 10'h140 + 10'(i), 4'b0010);
        for (int i = 0; i < 2; i++) load(2, 10'h380 + 10'(i), 4'b1000);
        repeat (4) step();
        rst_n = 1'b1;

        // Priority: FIFO0 fully drains before FIFO2.
        drain("prio_drain", 50);
        chk("prio_len", 32'(pop_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < pop_log.size(); i++) begin
            chk("prio_order", 32'(pop_log[i]), (i < 3) ? 32'd0 : 32'd2);
        end
        chk("prio_count", 32'(cnt), 32'd5);
        chk("prio_idle", 32'(st), 32'(MIdle));

        // Routing table, including a null word at the end.
        base = m_cnt;
        foreach (tbl[i]) load(0, tbl[i].w, tbl[i].p);
        drain("route_drain", 50);
        chk("route_count", 32'(cnt), 32'(base + 8'd4));
        chk("null_data", 32'(dout), 32'h000);

        // Backpressure while FIFO0 streams.
        for (int i = 0; i < 6; i++) load(0, 10'h100 + 10'(i), 4'b0010);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pop[0] !== 1'b1 && n < 20);
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL bp_start: got no pop expected pop within 20 cycles");
        end
        step();
        af = 4'b0010;
        @(negedge clk);
        #1;
        chk("bp_pop", 32'(pop), 32'h0);
        chk("bp_push", 32'(push), 32'b0010);
        step();
        step();
        chk("bp_pause", 32'(st), 32'(MPause));
        af = 4'b0000;
        drain("bp_drain", 50);

        // Preemption: FIFO1 becomes non-empty while FIFO3 streams.
        pop_log.delete();
        for (int i = 0; i < 6; i++) load(3, 10'h300 + 10'(i + 1), 4'b1000);
        repeat (3) step();
        load(1, 10'h0F0, 4'b0001);
        drain("pre_drain", 50);
        chk("pre_len", 32'(pop_log.size()), 32'd7);
        ones = 0;
        foreach (pop_log[i]) if (pop_log[i] == 1) ones++;
        chk("pre_seen", 32'(ones), 32'd1);
        chk("pre_last", 32'(pop_log[pop_log.size()-1]), 32'd3);

        // Reset mid-stream discards the stage word and clears the counter.
        for (int i = 0; i < 8; i++) load(0, 10'h200 + 10'(i), 4'b0100);
        repeat (4) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        drain("mid_drain", 50);

        // Wrap: 300 non-null words take the 8-bit counter through zero.
        base = m_cnt;
        for (int i = 0; i < 300; i++) load(2, {2'b10, 8'(i)}, 4'b0100);
        drain("wrap_drain", 1000);
        chk("wrap_count", 32'(cnt), 32'(base + 8'(300)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
